// File: rtl/regfile.sv
// regfile: 32 x 32-bit architectural register file with two combinational read
// ports, one clocked write port and a 3-bit ALU status register.
// Register 0 has no storage and always reads zero.
// Optional feature: define REGFILE_BYPASS_EN to forward the in-flight write
// data to a read port addressing the register being written.
module regfile #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [$clog2(NREGS)-1:0]   rsNum,
    input  logic [$clog2(NREGS)-1:0]   rtNum,
    output logic [WIDTH-1:0]           rsData,
    output logic [WIDTH-1:0]           rtData,
    input  logic [$clog2(NREGS)-1:0]   rdNum,
    input  logic [WIDTH-1:0]           rdData,
    input  logic                       rdWriteEnable,
    input  logic [2:0]                 flagIn,
    input  logic                       flagWriteEnable,
    output logic [2:0]                 flags
);

    localparam int unsigned AW = $clog2(NREGS);

    // Storage for registers 1..NREGS-1 only; index 0 is never allocated
    logic [WIDTH-1:0] regs_q [1:NREGS-1];
    logic [WIDTH-1:0] regs_d [1:NREGS-1];
    logic [2:0]       flags_q;
    logic [2:0]       flags_d;

    logic [WIDTH-1:0] rs_stored;
    logic [WIDTH-1:0] rt_stored;

    // Next-state for the register array: one decoded write, r0 writes dropped
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (rdWriteEnable && (rdNum == AW'(i))) begin
                regs_d[i] = rdData;
            end
        end
    end

    // Next-state for the status flags: capture on strobe, otherwise hold
    always_comb begin
        flags_d = flags_q;
        if (flagWriteEnable) begin
            flags_d = flagIn;
        end
    end

    // State registers; async reset clears everything and overrides writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    // Stored-value read decode for both ports; address 0 falls through to zero
    always_comb begin
        rs_stored = '0;
        rt_stored = '0;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (rsNum == AW'(i)) begin
                rs_stored = regs_q[i];
            end
            if (rtNum == AW'(i)) begin
                rt_stored = regs_q[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;

    // Forward the pending write to a matching read port, never for r0 or in reset
    always_comb begin
        wr_live = reset && rdWriteEnable && (rdNum != '0);
        rsData  = (wr_live && (rdNum == rsNum)) ? rdData : rs_stored;
        rtData  = (wr_live && (rdNum == rtNum)) ? rdData : rt_stored;
    end
`else
    // Read ports return stored contents only
    always_comb begin
        rsData = rs_stored;
        rtData = rt_stored;
    end
`endif

    assign flags = flags_q;

endmodule
